// File: rtl/life_controller.sv
// Game of Life board sequencer: play-mode FSM, setup cursor, and the
// toggle / gen_tick strobes that drive every cell instance.
module life_controller #(
  parameter int unsigned ROWS     = 16,
  parameter int unsigned COLS     = 16,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    setup_sw,
  input  logic                    run_sw,
  input  logic                    btn_up,
  input  logic                    btn_down,
  input  logic                    btn_left,
  input  logic                    btn_right,
  input  logic                    btn_toggle,
  input  logic                    btn_step,
  input  logic [1:0]              speed,
  output logic [$clog2(ROWS)-1:0] cursor_row,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    toggle,
  output logic                    setup,
  output logic                    gen_tick,
  output logic [CNT_W-1:0]        gen_count,
  output logic [1:0]              mode
);

  localparam int unsigned RW     = $clog2(ROWS);
  localparam int unsigned CW     = $clog2(COLS);
  localparam int unsigned PER_W  = $clog2(TICK_DIV * 8);
  localparam int unsigned PL_W   = PER_W + 1;
  localparam int unsigned N_KEYS = 6;
  localparam int unsigned K_UP   = 0;
  localparam int unsigned K_DOWN = 1;
  localparam int unsigned K_LEFT = 2;
  localparam int unsigned K_RGHT = 3;
  localparam int unsigned K_TOG  = 4;
  localparam int unsigned K_STEP = 5;

  typedef enum logic [1:0] {
    ST_SETUP   = 2'd0,
    ST_PAUSED  = 2'd1,
    ST_RUNNING = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_KEYS-1:0]   key_prev_q;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic                toggle_q, toggle_d;
  logic                tick_q, tick_d;
  logic                setup_q, setup_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [PER_W-1:0]    per_cnt_q, per_cnt_d;

  logic [N_KEYS-1:0]   keys_c;
  logic [N_KEYS-1:0]   rise_c;
  logic [PL_W-1:0]     per_lim_c;

  assign keys_c    = {btn_step, btn_toggle, btn_right, btn_left, btn_down, btn_up};
  assign rise_c    = keys_c & ~key_prev_q;
  // Last count value of the current period; wide enough for speed = 3.
  assign per_lim_c = ({1'b0, PER_W'(TICK_DIV)} << speed) - PL_W'(1);

  // Mode FSM next state; setup_sw overrides everything.
  always_comb begin
    state_d = state_q;
    if (setup_sw) begin
      state_d = ST_SETUP;
    end else begin
      case (state_q)
        ST_SETUP:   state_d = run_sw ? ST_RUNNING : ST_PAUSED;
        ST_PAUSED:  if (run_sw)  state_d = ST_RUNNING;
        ST_RUNNING: if (!run_sw) state_d = ST_PAUSED;
        default:    state_d = ST_SETUP;
      endcase
    end
  end

  // Cursor, strobes, period counter and generation count.
  always_comb begin
    row_d     = row_q;
    col_d     = col_q;
    toggle_d  = 1'b0;
    tick_d    = 1'b0;
    per_cnt_d = '0;
    setup_d   = (state_d == ST_SETUP);
    count_d   = count_q + CNT_W'(tick_q);

    if (state_q == ST_SETUP) begin
      if (rise_c[K_UP] && !rise_c[K_DOWN]) begin
        row_d = (row_q == '0) ? RW'(ROWS - 1) : row_q - RW'(1);
      end else if (rise_c[K_DOWN] && !rise_c[K_UP]) begin
        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
      end
      if (rise_c[K_LEFT] && !rise_c[K_RGHT]) begin
        col_d = (col_q == '0) ? CW'(COLS - 1) : col_q - CW'(1);
      end else if (rise_c[K_RGHT] && !rise_c[K_LEFT]) begin
        col_d = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
      end
      toggle_d = rise_c[K_TOG];
    end

    // >= lets a mid-period speed reduction fire on the next cycle.
    if (state_q == ST_RUNNING) begin
      if ({1'b0, per_cnt_q} >= per_lim_c) begin
        tick_d = 1'b1;
      end else begin
        per_cnt_d = per_cnt_q + PER_W'(1);
      end
    end else if (state_q == ST_PAUSED && rise_c[K_STEP]) begin
      tick_d = 1'b1;
    end

    if (state_d == ST_SETUP) begin
      tick_d  = 1'b0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_SETUP;
      key_prev_q <= keys_c;
      row_q      <= '0;
      col_q      <= '0;
      toggle_q   <= 1'b0;
      tick_q     <= 1'b0;
      setup_q    <= 1'b1;
      count_q    <= '0;
      per_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= keys_c;
      row_q      <= row_d;
      col_q      <= col_d;
      toggle_q   <= toggle_d;
      tick_q     <= tick_d;
      setup_q    <= setup_d;
      count_q    <= count_d;
      per_cnt_q  <= per_cnt_d;
    end
  end

  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign toggle     = toggle_q;
  assign setup      = setup_q;
  assign gen_tick   = tick_q;
  assign gen_count  = count_q;
  assign mode       = state_q;

endmodule

// File: doc/life_controller.md
# life_controller

Top-level sequencer for the Game of Life LED-matrix board. Owns the play mode (setup, paused, running) and the setup cursor. Generates the one-cycle `toggle` and `gen_tick` strobes that every cell instance consumes; cells advance one generation only on `gen_tick`. Sits between the synchronized board inputs (switches/keys) and the cell array plus display driver.

## Interface
- `ROWS`, default 16: grid rows.
- `COLS`, default 16: grid columns.
- `TICK_DIV`, default 25_000_000: base generation period in clocks, ≥1.
- `CNT_W`, default 16: width of `gen_count`.
- Reset: `reset`, synchronous, active-high. Clock: `clk`.
- `clk`  in  1  system clock
- `reset`  in  1  synchronous active-high reset
- `setup_sw`  in  1  level; 1 = setup mode requested
- `run_sw`  in  1  level; 1 = free-run generations when not in setup
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  synchronized active-high keys
- `btn_toggle`  in  1  synchronized key; flips the selected cell
- `btn_step`  in  1  synchronized key; single generation while paused
- `speed`  in  2  period = `TICK_DIV << speed`
- `cursor_row`  out  clog2(ROWS)  selected row
- `cursor_col`  out  clog2(COLS)  selected column
- `toggle`  out  1  one-cycle strobe to the selected cell
- `setup`  out  1  registered, 1 while state is SETUP
- `gen_tick`  out  1  one-cycle generation-advance strobe
- `gen_count`  out  CNT_W  generations since leaving setup, wraps
- `mode`  out  2  0 = SETUP, 1 = PAUSED, 2 = RUNNING

## Operation
- **Edge detect:** one prev register per key. Rise = key & ~prev. During reset, prev loads the live key value, so a key held through reset produces no edge.
- **FSM states:** SETUP, PAUSED, RUNNING. Reset state is SETUP.
- **Any state → SETUP** when `setup_sw`=1. This has highest priority.
- **SETUP exit** (when `setup_sw`=0): → RUNNING if `run_sw`=1, else → PAUSED.
- **PAUSED → RUNNING** when `run_sw`=1.
- **RUNNING → PAUSED** when `run_sw`=0.
- **Cursor:** moves only in SETUP, one step per rise.
  - up: row−1; down: row+1; left: col−1; right: col+1.
  - Wraps modulo ROWS/COLS (row 0 up → ROWS−1; col COLS−1 right → 0).
  - Up and down rising in the same cycle: row unchanged. Left and right together: col unchanged.
  - Row and column moves in the same cycle both apply.
  - Cursor is held outside SETUP.
- **toggle:** asserted for one cycle after a `btn_toggle` rise, only in SETUP. It is ignored in other states.
- **Period counter:** counts only in RUNNING.
  - When the counter ≥ `(TICK_DIV<<speed)−1`, `gen_tick` fires and the counter clears.
  - The ≥ comparison means that lowering `speed` mid-count fires on the next cycle.
  - The counter clears in any state other than RUNNING, so the first tick after entering RUNNING comes a full period later.
- **Step:** a `btn_step` rise while PAUSED fires one `gen_tick`. It is ignored in SETUP and RUNNING.
- **gen_count:** increments by 1 per `gen_tick` and wraps at 2^CNT_W. It clears to 0 on the cycle the FSM enters SETUP and holds while in SETUP.
- **gen_tick and setup:** `gen_tick` is never asserted while the state is SETUP or `setup`=1.

## Timing
- All outputs are registered.
- **Reset values:** cursor 0,0; `toggle`=0; `gen_tick`=0; `gen_count`=0; `setup`=1; `mode`=0. Period counter is 0.
- **Key edge** sampled in cycle N:
  - cursor updates and `toggle`/`gen_tick` (step) are visible in cycle N+1;
  - `gen_count` updates in N+2.
- **Mode change:** a switch change sampled in cycle N → `mode`/`setup` change in N+1.
- **Same-cycle step and mode change:** a step rise in the same cycle as a `setup_sw` or `run_sw` change is evaluated against the current state (PAUSED). The tick fires unless `setup_sw`=1, which suppresses it.
- **RUNNING tick spacing:** consecutive `gen_tick` pulses are exactly `TICK_DIV<<speed` cycles apart. With `TICK_DIV`=1 and `speed`=0, `gen_tick` is high every cycle.
- **Counter width:** wide enough for `TICK_DIV*8−1`.
- **Reset mid-RUNNING:** all outputs return to reset values on the next cycle. No `gen_tick` is emitted after reset assertion.

## Test plan
- **Reset with keys held:** reset with `btn_right`=1 held, release reset → cursor stays 0,0; `mode`=0; `setup`=1; no `toggle`.
- **Cursor wrap:** in SETUP, 1 `btn_up` pulse → row 15. 17 `btn_right` pulses → col 1. Simultaneous up+down rise → row unchanged.
- **Toggle gating:** in SETUP, `btn_toggle` pulse → `toggle` high exactly 1 cycle. With `setup_sw`=0 and `run_sw`=0 (PAUSED), `btn_toggle` → no `toggle`. In PAUSED, `btn_step` → one `gen_tick`; `gen_count` 0→1.
- **Run timing:** `TICK_DIV`=4, `speed`=1, `run_sw`=1 → `gen_tick` every 8 cycles. 5 ticks → `gen_count`=5. Switch `speed` to 0 at counter 6 → tick next cycle, then every 4 cycles.
- **Setup override:** `setup_sw`=1 while RUNNING → `mode`=0 next cycle, `gen_count`=0, no further ticks. Released with `run_sw`=1 → first tick 8 cycles after `mode`=2.
- **Mid-run reset:** reset asserted one cycle before an expected tick → no tick; all outputs at reset values.
